// File: rtl/div_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational divider.
// Optional macro DIV_ZERO_CHECK_EN: a zero divisor bypasses the divider and returns all ones with dz_err.
module div_arbiter #(
    parameter int unsigned Data_Depth    = 8,
    parameter int unsigned Divider_Depth = 8,
    parameter int          Settle_Cycles = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_valid,
    input  logic                       req1_valid,
    output logic                       req0_ready,
    output logic                       req1_ready,
    input  logic [4*Data_Depth-1:0]    req0_a,
    input  logic [4*Data_Depth-1:0]    req1_a,
    input  logic [4*Divider_Depth-1:0] req0_b,
    input  logic [4*Divider_Depth-1:0] req1_b,
    output logic                       rsp0_valid,
    output logic                       rsp1_valid,
    output logic [4*Data_Depth-1:0]    rsp0_q,
    output logic [4*Data_Depth-1:0]    rsp1_q,
    output logic [4*Data_Depth-1:0]    div_a,
    output logic [4*Divider_Depth-1:0] div_b,
    input  logic [4*Data_Depth-1:0]    div_c,
    output logic                       busy,
    output logic                       dz_err
);

    localparam int unsigned AW     = 4 * Data_Depth;
    localparam int unsigned BW     = 4 * Divider_Depth;
    localparam int unsigned SETTLE = (Settle_Cycles < 1) ? 32'd1 : 32'(Settle_Cycles);
    localparam int unsigned CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            last_grant_q;
    logic            id_q;
    logic [AW-1:0]   a_q;
    logic [BW-1:0]   b_q;
    logic [AW-1:0]   q0_q;
    logic [AW-1:0]   q1_q;
    logic            rsp0_valid_q;
    logic            rsp1_valid_q;
    logic            dz_q;

    logic            accept;
    logic            grant;
    logic [AW-1:0]   sel_a;
    logic [BW-1:0]   sel_b;
    logic            zero_b;

    // Grant selection: only in IDLE, contention resolved against the last winner
    always_comb begin
        accept = 1'b0;
        grant  = 1'b0;
        if (state_q == IDLE && !rst) begin
            accept = req0_valid | req1_valid;
            if (req0_valid && req1_valid) begin
                grant = ~last_grant_q;
            end else begin
                grant = req1_valid;
            end
        end
    end

    assign req0_ready = accept & ~grant;
    assign req1_ready = accept & grant;
    assign sel_a      = grant ? req1_a : req0_a;
    assign sel_b      = grant ? req1_b : req0_b;

`ifdef DIV_ZERO_CHECK_EN
    assign zero_b = (sel_b == '0);
    assign dz_err = dz_q;
`else
    assign zero_b = 1'b0;
    assign dz_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            q0_q         <= '0;
            q1_q         <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            dz_q         <= 1'b0;
        end else begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            dz_q         <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q          <= sel_a;
                        b_q          <= sel_b;
                        id_q         <= grant;
                        last_grant_q <= grant;
                        cnt_q        <= CW'(SETTLE - 1);
                        if (zero_b) begin
                            // Divide-by-zero short cut: answer immediately without using the divider
                            state_q <= DONE;
                            dz_q    <= 1'b1;
                            if (grant) begin
                                q1_q         <= '1;
                                rsp1_valid_q <= 1'b1;
                            end else begin
                                q0_q         <= '1;
                                rsp0_valid_q <= 1'b1;
                            end
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        if (id_q) begin
                            q1_q         <= div_c;
                            rsp1_valid_q <= 1'b1;
                        end else begin
                            q0_q         <= div_c;
                            rsp0_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign div_a      = a_q;
    assign div_b      = b_q;
    assign rsp0_q     = q0_q;
    assign rsp1_q     = q1_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign busy       = (state_q != IDLE);

endmodule
